accel_stream_loader: RTL and testbench

- Upstream feeder for the CNN accelerator top.
- Accepts a byte stream (valid/ready, with a last marker and a per-frame target select) from the CPU side.
- Packs bytes into 64-bit words and drives the accelerator's picture/weight external write ports.
- After each complete picture frame it pulses the accelerator start, waits for done, and returns the predicted label through a result handshake.

---
 rtl/accel_stream_loader.sv | 175 +++++++++++++++++
 tb/tb_accel_stream_loader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_stream_loader.sv
// Byte-stream loader for the CNN accelerator: packs bytes into 64-bit words,
// writes picture/weight memories, then runs one inference per picture frame.
module accel_stream_loader #(
  parameter int unsigned PIC_WORDS      = 98,
  parameter int unsigned WGT_WORDS      = 128,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  input  logic        s_tgt,
  output logic        picture_ext_we,
  output logic [6:0]  picture_ext_addr,
  output logic [63:0] picture_ext_data,
  output logic        weight_ext_we,
  output logic [6:0]  weight_ext_addr,
  output logic [63:0] weight_ext_data,
  output logic        acc_start,
  input  logic        acc_done,
  input  logic [3:0]  acc_label,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [3:0]  res_label,
  output logic        res_timeout,
  output logic        weights_loaded,
  output logic        ovf
);

  typedef enum logic [2:0] {IDLE, PACK, WRITE, START, WAIT, RESULT} state_t;

  localparam logic [7:0]  PIC_LIM = 8'(PIC_WORDS);
  localparam logic [7:0]  WGT_LIM = 8'(WGT_WORDS);
  localparam logic [15:0] T_LAST  = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic        tgt;
  logic        last_q;
  logic [7:0]  word_cnt;
  logic [2:0]  byte_cnt;
  logic [63:0] pack;
  logic [15:0] tcnt;
  logic [6:0]  pic_addr_q, wgt_addr_q;
  logic [63:0] pic_data_q, wgt_data_q;
  logic        accept, at_limit;

  assign accept   = s_valid && s_ready;
  assign at_limit = (state == PACK) && (word_cnt >= (tgt ? WGT_LIM : PIC_LIM));

  // Write ports show the live word in WRITE and otherwise hold the last word written.
  assign picture_ext_addr = picture_ext_we ? word_cnt[6:0] : pic_addr_q;
  assign picture_ext_data = picture_ext_we ? pack : pic_data_q;
  assign weight_ext_addr  = weight_ext_we ? word_cnt[6:0] : wgt_addr_q;
  assign weight_ext_data  = weight_ext_we ? pack : wgt_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next     = state;
    s_ready        = 1'b0;
    picture_ext_we = 1'b0;
    weight_ext_we  = 1'b0;
    acc_start      = 1'b0;
    res_valid      = 1'b0;
    unique case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (accept) state_next = s_last ? WRITE : PACK;
      end
      PACK: begin
        s_ready = 1'b1;
        if (accept) begin
          if (at_limit) begin
            if (s_last) state_next = tgt ? IDLE : START;
          end else if (s_last || byte_cnt == 3'd7) begin
            state_next = WRITE;
          end
        end
      end
      WRITE: begin
        picture_ext_we = !tgt;
        weight_ext_we  = tgt;
        if (last_q) state_next = tgt ? IDLE : START;
        else        state_next = PACK;
      end
      START: begin
        acc_start  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (acc_done || tcnt == T_LAST) state_next = RESULT;
      end
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt            <= 1'b0;
      last_q         <= 1'b0;
      word_cnt       <= '0;
      byte_cnt       <= '0;
      pack           <= '0;
      tcnt           <= '0;
      pic_addr_q     <= '0;
      pic_data_q     <= '0;
      wgt_addr_q     <= '0;
      wgt_data_q     <= '0;
      res_label      <= '0;
      res_timeout    <= 1'b0;
      weights_loaded <= 1'b0;
      ovf            <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            tgt      <= s_tgt;
            word_cnt <= '0;
            pack     <= {56'd0, s_data};
            byte_cnt <= 3'd1;
            last_q   <= s_last;
          end
        end
        PACK: begin
          if (accept) begin
            if (at_limit) begin
              ovf <= 1'b1;
              if (s_last && tgt) weights_loaded <= 1'b1;
            end else begin
              pack[{byte_cnt, 3'b000} +: 8] <= s_data;
              byte_cnt <= byte_cnt + 3'd1;
              last_q   <= s_last;
            end
          end
        end
        WRITE: begin
          if (tgt) begin
            wgt_addr_q <= word_cnt[6:0];
            wgt_data_q <= pack;
            if (last_q) weights_loaded <= 1'b1;
          end else begin
            pic_addr_q <= word_cnt[6:0];
            pic_data_q <= pack;
          end
          word_cnt <= word_cnt + 8'd1;
          byte_cnt <= '0;
          pack     <= '0;
        end
        START: tcnt <= '0;
        WAIT: begin
          if (acc_done) begin
            res_label   <= acc_label;
            res_timeout <= 1'b0;
          end else if (tcnt == T_LAST) begin
            res_label   <= 4'hF;
            res_timeout <= 1'b1;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_stream_loader.sv
// Randomized scoreboard bench for accel_stream_loader: frame-level reference
// model feeds expected writes/results; a negedge monitor pops and compares.
module tb_accel_stream_loader;

  localparam int PIC = 98;
  localparam int WGT = 128;
  localparam int T   = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ready, s_last, s_tgt;
  logic [7:0]  s_data;
  logic        picture_ext_we, weight_ext_we;
  logic [6:0]  picture_ext_addr, weight_ext_addr;
  logic [63:0] picture_ext_data, weight_ext_data;
  logic        acc_start, acc_done;
  logic [3:0]  acc_label;
  logic        res_valid, res_ready, res_timeout;
  logic [3:0]  res_label;
  logic        weights_loaded, ovf;

  accel_stream_loader #(.PIC_WORDS(PIC), .WGT_WORDS(WGT), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_tgt(s_tgt),
    .picture_ext_we(picture_ext_we), .picture_ext_addr(picture_ext_addr),
    .picture_ext_data(picture_ext_data),
    .weight_ext_we(weight_ext_we), .weight_ext_addr(weight_ext_addr),
    .weight_ext_data(weight_ext_data),
    .acc_start(acc_start), .acc_done(acc_done), .acc_label(acc_label),
    .res_valid(res_valid), .res_ready(res_ready), .res_label(res_label),
    .res_timeout(res_timeout), .weights_loaded(weights_loaded), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic tgt; logic [6:0] addr; logic [63:0] data;} wr_t;
  typedef struct {logic [3:0] label; logic to; int cyc;} res_t;
  typedef struct {int d; logic [3:0] lab;} dl_t;

  wr_t  wq[$];
  res_t rq[$];
  dl_t  dq[$];
  logic [7:0] fb[$];
  logic ovf_m, wl_m;
  int   cyc = 0;
  int   errors = 0, checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
  endtask

  // Monitor: writes, start pulse, result handshake
  logic prev_rv = 1'b0, prev_start = 1'b0, prev_ready = 1'b0, prev_to = 1'b0;
  logic [3:0] prev_label = '0;
  wr_t  mw, gw;
  res_t mr;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rv = 1'b0; prev_start = 1'b0;
    end else begin
      if (picture_ext_we || weight_ext_we) begin
        chk("we_exclusive", 80'(picture_ext_we & weight_ext_we), 80'(0));
        chk("ready_in_write", 80'(s_ready), 80'(0));
        if (wq.size() == 0) fail("unexpected_write");
        else begin
          mw = wq.pop_front();
          gw = {weight_ext_we, weight_ext_we ? weight_ext_addr : picture_ext_addr,
                weight_ext_we ? weight_ext_data : picture_ext_data};
          chk("write", 80'(gw), 80'(mw));
        end
      end
      if (acc_start) begin
        chk("ready_in_start", 80'(s_ready), 80'(0));
        chk("start_one_cycle", 80'(prev_start), 80'(0));
      end
      if (res_valid) begin
        chk("ready_in_result", 80'(s_ready), 80'(0));
        if (!prev_rv) begin
          if (rq.size() == 0) fail("unexpected_result");
          else begin
            mr = rq.pop_front();
            chk("res_label", 80'(res_label), 80'(mr.label));
            chk("res_timeout", 80'(res_timeout), 80'(mr.to));
            chk("res_latency", 80'(cyc), 80'(mr.cyc));
          end
        end else begin
          chk("res_stable", 80'({res_label, res_timeout}), 80'({prev_label, prev_to}));
        end
      end else if (prev_rv) begin
        chk("res_held_until_ready", 80'(prev_ready), 80'(1));
      end
      prev_rv = res_valid; prev_start = acc_start; prev_ready = res_ready;
      prev_label = res_label; prev_to = res_timeout;
    end
  end

  // Accelerator responder: done after d cycles (d<0: never; -2: frame is aborted)
  dl_t  rd;
  res_t er;
  logic ok;
  initial begin
    acc_done = 1'b0;
    acc_label = '0;
    forever begin
      @(negedge clk);
      acc_label = 4'($urandom);
      if (rst_n && acc_start) begin
        if (dq.size() == 0) fail("unexpected_start");
        else begin
          rd = dq.pop_front();
          if (rd.d != -2) begin
            ok = (rd.d >= 1) && (rd.d <= T);
            er.label = ok ? rd.lab : 4'hF;
            er.to = !ok;
            er.cyc = cyc + (ok ? rd.d + 1 : T + 1);
            rq.push_back(er);
            if (rd.d >= 0) begin
              repeat (rd.d) @(negedge clk);
              acc_done = 1'b1;
              acc_label = rd.lab;
              @(negedge clk);
              acc_done = 1'b0;
            end
          end
        end
      end
    end
  end

  // Result consumer with random back-pressure
  initial begin
    res_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (res_valid && !res_ready) begin
        repeat ($urandom_range(0, 10)) @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic l, input logic t, input int gap);
    int n = 0;
    s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    s_valid = 1'b1; s_data = b; s_last = l; s_tgt = t;
    while (!s_ready && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) fail("ready_timeout");
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // Reference model at frame level: words, limit, stickies, start expectation
  task automatic send_frame(input logic t, input int d, input logic [3:0] lab, input bit gaps);
    int n = fb.size();
    int lim = t ? WGT : PIC;
    logic [63:0] w;
    wr_t e;
    dl_t x;
    for (int i = 0; i < (n + 7) / 8; i++) begin
      w = '0;
      for (int j = 0; j < 8; j++)
        if (i * 8 + j < n) w[j*8 +: 8] = fb[i*8 + j];
      if (i < lim) begin
        e.tgt = t; e.addr = 7'(i); e.data = w;
        wq.push_back(e);
      end else ovf_m = 1'b1;
    end
    if (t) wl_m = 1'b1;
    else begin
      x.d = d; x.lab = lab;
      dq.push_back(x);
    end
    for (int i = 0; i < n; i++)
      send_byte(fb[i], i == n - 1, (i == 0) ? t : 1'($urandom),
                (gaps && $urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(wq.size() == 0 && rq.size() == 0 && dq.size() == 0 && !res_valid && s_ready)
           && n < 3000) begin
      @(negedge clk); n++;
    end
    if (n >= 3000) fail({name, "_idle_timeout"});
    chk({name, "_ovf"}, 80'(ovf), 80'(ovf_m));
    chk({name, "_weights_loaded"}, 80'(weights_loaded), 80'(wl_m));
  endtask

  task automatic check_zero(input string name);
    chk({name, "_pic"}, 80'({picture_ext_we, picture_ext_addr, picture_ext_data}), 80'(0));
    chk({name, "_wgt"}, 80'({weight_ext_we, weight_ext_addr, weight_ext_data}), 80'(0));
    chk({name, "_ctrl"}, 80'({acc_start, res_valid, res_label, res_timeout, weights_loaded, ovf}),
        80'(0));
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0;
    s_valid = 1'b0; s_last = 1'b0;
    #1;
    check_zero(name);
    wq.delete(); rq.delete(); dq.delete();
    ovf_m = 1'b0; wl_m = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic random_frame();
    int n = $urandom_range(1, 40);
    int d;
    fb.delete();
    for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
    case ($urandom_range(0, 5))
      0: d = 0;
      1: d = 1;
      2: d = T;
      3: d = T + 1;
      4: d = -1;
      default: d = $urandom_range(2, T - 1);
    endcase
    send_frame(1'($urandom), d, 4'($urandom), 1'b1);
    wait_idle("random");
  endtask

  initial begin
    int n;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_tgt = 1'b0;
    ovf_m = 1'b0; wl_m = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    fb.delete();
    for (int i = 1; i <= 16; i++) fb.push_back(8'(i));
    send_frame(1'b0, 3, 4'd7, 1'b0);
    wait_idle("pic16");

    fb.delete();
    fb.push_back(8'hAA); fb.push_back(8'hBB); fb.push_back(8'hCC);
    send_frame(1'b1, 0, 4'd0, 1'b0);
    wait_idle("wgt3");

    fb.delete();
    for (int i = 0; i < 13; i++) fb.push_back(8'($urandom));
    send_frame(1'b0, -1, 4'd2, 1'b1);
    wait_idle("timeout");

    for (int k = 0; k < 12; k++) random_frame();

    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0, 1'b0, 0);
    do_reset("rst_pack");

    fb.delete();
    for (int i = 0; i < 20; i++) fb.push_back(8'($urandom));
    send_frame(1'b0, -2, 4'd0, 1'b0);
    n = 0;
    while (dq.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) fail("start_before_wait_reset");
    repeat (3) @(negedge clk);
    do_reset("rst_wait");

    fb.delete();
    for (int i = 0; i < 9; i++) fb.push_back(8'($urandom));
    send_frame(1'b0, 5, 4'd9, 1'b0);
    wait_idle("after_reset");

    fb.delete();
    for (int i = 0; i < 792; i++) fb.push_back(8'($urandom));
    send_frame(1'b0, 4, 4'd3, 1'b0);
    wait_idle("pic_ovf");

    for (int k = 0; k < 6; k++) random_frame();

    chk("writes_drained", 80'(wq.size()), 80'(0));
    chk("results_drained", 80'(rq.size()), 80'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule
